// File: rtl/store_pkg.sv
// Shared encodings for the store read-modify-write sequencer: store sizes,
// FSM states and the width of the read-latency counter.
package store_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        WRITE,
        DONE
    } state_e;

    // Wide enough to count 0..MEM_LAT-1 for MEM_LAT up to 4.
    localparam int CNT_W = 2;

endpackage

// File: rtl/store_merge.sv
// Lane merge for sub-word stores: overlays the store data onto the word read
// back from memory. Lanes are fixed to the low bits regardless of address.
module store_merge
    import store_pkg::*;
(
    input  size_e       size,
    input  logic [31:0] mdr,
    input  logic [31:0] data,
    output logic [31:0] merged
);

    always_comb begin
        case (size)
            SZ_BYTE: merged = {mdr[31:8], data[7:0]};
            SZ_HALF: merged = {mdr[31:16], data[15:0]};
            SZ_WORD: merged = data;
            default: merged = mdr;
        endcase
    end

endmodule

// File: rtl/store_rmw_sequencer.sv
// Store sequencer: word stores write directly, byte/halfword stores read the
// target word, merge the new lanes in and write it back once.
module store_rmw_sequencer
    import store_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_data,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        done,
    output logic        err
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    size_e            size_q, size_d;
    logic [31:0]      data_q, data_d;
    logic [31:0]      mdr_q, mdr_d;
    logic [31:0]      merged;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             mem_wr_q, mem_wr_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Merge sees the values that will be registered, so the write word is
    // ready in the same edge that enters WRITE.
    store_merge u_merge (
        .size   (size_d),
        .mdr    (mdr_d),
        .data   (data_d),
        .merged (merged)
    );

    assign req_ready = (state_q == IDLE) && !reset;

    always_comb begin
        // NOTE: every _d gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        data_d  = data_q;
        mdr_d   = mdr_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d = req_addr;
                    size_d = size_e'(req_size);
                    data_d = req_data;
                    cnt_d  = '0;
                    case (size_e'(req_size))
                        SZ_WORD: state_d = WRITE;
                        SZ_RSVD: state_d = DONE;
                        default: state_d = READ;
                    endcase
                end
            end
            READ: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAPTURE: begin
                mdr_d   = mem_rdata;
                state_d = WRITE;
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        mem_wr_d    = (state_d == WRITE);
        mem_addr_d  = (state_d inside {READ, CAPTURE, WRITE}) ? addr_d : '0;
        mem_wdata_d = (state_d == WRITE) ? merged : '0;
        done_d      = (state_d == DONE);
        err_d       = (state_d == DONE) && (size_d == SZ_RSVD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: non-blocking throughout, so every flop samples pre-edge values.
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            size_q      <= SZ_BYTE;
            data_q      <= '0;
            // NOTE: the MDR is cleared on reset so no stale read data survives an abort.
            mdr_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            data_q      <= data_d;
            mdr_q       <= mdr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wr_q    <= mem_wr_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wr    = mem_wr_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_store_rmw_sequencer.sv
// Bench for store_rmw_sequencer: two instances (read latency 1 and 3), each
// with a small latency-accurate memory model and a shared write/done scoreboard.
module tb_store_rmw_sequencer;
    import store_pkg::*;

    localparam int NDUT     = 2;
    localparam int MAX_WAIT = 40;

    typedef struct {
        int          dut;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } wr_exp_t;

    typedef struct {
        int   dut;
        logic err;
        int   cyc;
    } done_exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [NDUT-1:0] req_valid;
    logic [NDUT-1:0] req_ready;
    logic [NDUT-1:0] mem_wr;
    logic [NDUT-1:0] done;
    logic [NDUT-1:0] err;
    logic [31:0]     req_addr;
    logic [31:0]     req_data;
    logic [1:0]      req_size;
    logic [31:0]     mem_addr  [NDUT];
    logic [31:0]     mem_wdata [NDUT];
    logic [31:0]     mem_rdata [NDUT];
    logic [31:0]     mem       [NDUT][256];
    logic [31:0]     apipe     [NDUT][4];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    wr_exp_t   wq[$];
    done_exp_t dq[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Address history per memory; read data appears MEM_LAT cycles after the address.
    always @(posedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            apipe[d][0] <= mem_addr[d];
            for (int i = 1; i < 4; i++) apipe[d][i] <= apipe[d][i-1];
        end
    end

    assign mem_rdata[0] = mem[0][apipe[0][0][7:0]];
    assign mem_rdata[1] = mem[1][apipe[1][2][7:0]];

    store_rmw_sequencer #(.MEM_LAT(1)) dut_lat1 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_data  (req_data),
        .mem_addr  (mem_addr[0]),
        .mem_wr    (mem_wr[0]),
        .mem_wdata (mem_wdata[0]),
        .mem_rdata (mem_rdata[0]),
        .done      (done[0]),
        .err       (err[0])
    );

    store_rmw_sequencer #(.MEM_LAT(3)) dut_lat3 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_data  (req_data),
        .mem_addr  (mem_addr[1]),
        .mem_wr    (mem_wr[1]),
        .mem_wdata (mem_wdata[1]),
        .mem_rdata (mem_rdata[1]),
        .done      (done[1]),
        .err       (err[1])
    );

    // One cycle: land on the falling edge, then score any write or done pulse.
    task automatic step();
        wr_exp_t   we;
        done_exp_t de;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            if (mem_wr[d] !== 1'b0) begin
                total++;
                if (wq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_wr: dut=%0d cyc=%0d addr=%h wdata=%h, required no write",
                             d, cyc, mem_addr[d], mem_wdata[d]);
                end else begin
                    we = wq.pop_front();
                    if (we.dut != d || mem_addr[d] !== we.addr || mem_wdata[d] !== we.wdata || cyc != we.cyc) begin
                        bad++;
                        $display("FAIL wr_txn: got dut=%0d cyc=%0d addr=%h wdata=%h, required dut=%0d cyc=%0d addr=%h wdata=%h",
                                 d, cyc, mem_addr[d], mem_wdata[d], we.dut, we.cyc, we.addr, we.wdata);
                    end
                end
                mem[d][mem_addr[d][7:0]] = mem_wdata[d];
            end
            if (done[d] !== 1'b0 || err[d] !== 1'b0) begin
                total++;
                if (dq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done: dut=%0d cyc=%0d done=%b err=%b, required no pulse",
                             d, cyc, done[d], err[d]);
                end else begin
                    de = dq.pop_front();
                    if (de.dut != d || done[d] !== 1'b1 || err[d] !== de.err || cyc != de.cyc) begin
                        bad++;
                        $display("FAIL done_txn: got dut=%0d cyc=%0d done=%b err=%b, required dut=%0d cyc=%0d done=1 err=%b",
                                 d, cyc, done[d], err[d], de.dut, de.cyc, de.err);
                    end
                end
            end
        end
    endtask

    // Present a request, wait for acceptance and push the expected write/done.
    task automatic issue(input int d, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] dat, output int acc);
        int          waited;
        int          lat;
        int          wr_cyc;
        logic [31:0] old;
        logic [31:0] wd;
        waited = 0;
        lat    = (d == 0) ? 1 : 3;
        req_addr = a;
        req_size = sz;
        req_data = dat;
        req_valid[d] = 1'b1;
        while (req_ready[d] !== 1'b1 && waited < MAX_WAIT) begin
            step();
            waited++;
        end
        acc = cyc + 1;
        if (req_ready[d] !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: dut=%0d req_ready=%b after %0d cycles, required 1", d, req_ready[d], waited);
            req_valid[d] = 1'b0;
            return;
        end
        old = mem[d][a[7:0]];
        case (sz)
            2'b00:   wd = {old[31:8], dat[7:0]};
            2'b01:   wd = {old[31:16], dat[15:0]};
            default: wd = dat;
        endcase
        if (sz == 2'b11) begin
            dq.push_back('{d, 1'b1, acc});
        end else begin
            wr_cyc = (sz == 2'b10) ? acc : acc + lat + 1;
            wq.push_back('{d, a, wd, wr_cyc});
            dq.push_back('{d, 1'b0, wr_cyc + 1});
        end
        step();
        // Scramble the inputs: the accepted request must already be latched.
        req_valid[d] = 1'b0;
        req_addr = $urandom;
        req_data = $urandom;
        req_size = 2'($urandom);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((wq.size() != 0 || dq.size() != 0) && n < MAX_WAIT) begin
            step();
            n++;
        end
        total++;
        if (wq.size() != 0 || dq.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: pending wr=%0d done=%0d, required 0 and 0", tag, wq.size(), dq.size());
            wq.delete();
            dq.delete();
        end
        repeat (2) step();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_size  = '0;
        req_data  = '0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            total++;
            if (req_ready[d] !== 1'b0 || mem_wr[d] !== 1'b0 || done[d] !== 1'b0 || err[d] !== 1'b0 ||
                mem_addr[d] !== 32'h0 || mem_wdata[d] !== 32'h0) begin
                bad++;
                $display("FAIL reset_outputs: dut=%0d ready=%b wr=%b done=%b err=%b addr=%h wdata=%h, required all 0",
                         d, req_ready[d], mem_wr[d], done[d], err[d], mem_addr[d], mem_wdata[d]);
            end
        end
        reset = 1'b0;
        step();
        for (int d = 0; d < NDUT; d++) begin
            total++;
            if (req_ready[d] !== 1'b1) begin
                bad++;
                $display("FAIL reset_ready: dut=%0d req_ready=%b, required 1", d, req_ready[d]);
            end
        end
    endtask

    task automatic test_lat1_stores();
        int acc;
        mem[0][8'h40] = 32'hAABBCCDD;
        issue(0, 32'h40, 2'b00, 32'h11223344, acc);
        drain("lat1_byte");
        total++;
        if (mem[0][8'h40] !== 32'hAABBCC44) begin
            bad++;
            $display("FAIL lat1_byte_word: got %h, required aabbcc44", mem[0][8'h40]);
        end
        mem[0][8'h40] = 32'hAABBCCDD;
        issue(0, 32'h40, 2'b01, 32'h11223344, acc);
        drain("lat1_half");
        total++;
        if (mem[0][8'h40] !== 32'hAABB3344) begin
            bad++;
            $display("FAIL lat1_half_word: got %h, required aabb3344", mem[0][8'h40]);
        end
        mem[0][8'h40] = 32'hAABBCCDD;
        issue(0, 32'h40, 2'b10, 32'h11223344, acc);
        drain("lat1_word");
        total++;
        if (mem[0][8'h40] !== 32'h11223344) begin
            bad++;
            $display("FAIL lat1_word_word: got %h, required 11223344", mem[0][8'h40]);
        end
    endtask

    task automatic test_low_addr_bits();
        int acc;
        mem[0][8'h43] = 32'hCAFEF00D;
        issue(0, 32'h43, 2'b00, 32'h00000077, acc);
        drain("low_addr_byte");
        total++;
        if (mem[0][8'h43] !== 32'hCAFEF077) begin
            bad++;
            $display("FAIL low_addr_byte: got %h, required cafef077", mem[0][8'h43]);
        end
        mem[0][8'h42] = 32'h55667788;
        issue(0, 32'h42, 2'b01, 32'h9999ABCD, acc);
        drain("low_addr_half");
        total++;
        if (mem[0][8'h42] !== 32'h5566ABCD) begin
            bad++;
            $display("FAIL low_addr_half: got %h, required 5566abcd", mem[0][8'h42]);
        end
    endtask

    task automatic test_lat3_stores();
        int acc;
        mem[1][8'h40] = 32'h12345678;
        issue(1, 32'h40, 2'b00, 32'h000000FF, acc);
        drain("lat3_byte");
        total++;
        if (mem[1][8'h40] !== 32'h123456FF) begin
            bad++;
            $display("FAIL lat3_byte_word: got %h, required 123456ff", mem[1][8'h40]);
        end
        mem[1][8'h44] = 32'h89ABCDEF;
        issue(1, 32'h44, 2'b01, 32'hFFFF0102, acc);
        drain("lat3_half");
        total++;
        if (mem[1][8'h44] !== 32'h89AB0102) begin
            bad++;
            $display("FAIL lat3_half_word: got %h, required 89ab0102", mem[1][8'h44]);
        end
        issue(1, 32'h48, 2'b10, 32'h0F0F0F0F, acc);
        drain("lat3_word");
    endtask

    task automatic test_reserved();
        int acc;
        mem[0][8'h60] = 32'h600D600D;
        mem[1][8'h60] = 32'h700D700D;
        issue(0, 32'h60, 2'b11, 32'hFFFFFFFF, acc);
        drain("rsvd_lat1");
        issue(1, 32'h60, 2'b11, 32'hFFFFFFFF, acc);
        drain("rsvd_lat3");
        total++;
        if (mem[0][8'h60] !== 32'h600D600D || mem[1][8'h60] !== 32'h700D700D) begin
            bad++;
            $display("FAIL rsvd_mem: got %h %h, required 600d600d 700d700d", mem[0][8'h60], mem[1][8'h60]);
        end
    endtask

    task automatic test_back_to_back();
        int acc1;
        int acc2;
        mem[0][8'h50] = 32'h01020304;
        issue(0, 32'h50, 2'b00, 32'hA5A5A5F0, acc1);
        issue(0, 32'h50, 2'b01, 32'h0000BEEF, acc2);
        drain("b2b");
        total++;
        if (acc2 != acc1 + 5) begin
            bad++;
            $display("FAIL b2b_accept: second accepted %0d cycles after first, required 5", acc2 - acc1);
        end
        total++;
        if (mem[0][8'h50] !== 32'h0102BEEF) begin
            bad++;
            $display("FAIL b2b_word: got %h, required 0102beef", mem[0][8'h50]);
        end
    endtask

    // Start a store, assert reset at the given point and confirm the abort.
    task automatic test_reset_abort(input int d, input logic [1:0] sz, input logic [31:0] a, input string tag);
        int acc;
        issue(d, a, sz, 32'h13579BDF, acc);
        reset = 1'b1;
        wq.delete();
        dq.delete();
        step();
        total++;
        if (req_ready[d] !== 1'b0 || mem_wr[d] !== 1'b0 || done[d] !== 1'b0 || err[d] !== 1'b0 ||
            mem_addr[d] !== 32'h0 || mem_wdata[d] !== 32'h0) begin
            bad++;
            $display("FAIL %s_outputs: ready=%b wr=%b done=%b err=%b addr=%h wdata=%h, required all 0",
                     tag, req_ready[d], mem_wr[d], done[d], err[d], mem_addr[d], mem_wdata[d]);
        end
        step();
        reset = 1'b0;
        step();
        total++;
        if (req_ready[d] !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready: req_ready=%b, required 1", tag, req_ready[d]);
        end
        repeat (8) step();
    endtask

    task automatic test_reset_during_read();
        mem[1][8'h88] = 32'h0BADF00D;
        test_reset_abort(1, 2'b00, 32'h88, "rst_read");
        total++;
        if (mem[1][8'h88] !== 32'h0BADF00D) begin
            bad++;
            $display("FAIL rst_read_mem: got %h, required 0badf00d", mem[1][8'h88]);
        end
    endtask

    task automatic test_reset_during_write();
        test_reset_abort(0, 2'b10, 32'h90, "rst_write");
    endtask

    task automatic test_random();
        int          acc;
        int          d;
        logic [31:0] a;
        logic [1:0]  sz;
        logic [31:0] dat;
        for (int n = 0; n < 16; n++) begin
            d   = n % 2;
            a   = 32'($urandom_range(1, 255));
            sz  = 2'($urandom_range(0, 3));
            dat = $urandom;
            issue(d, a, sz, dat, acc);
            drain("random");
        end
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 256; i++) mem[d][i] = {8'(i), 8'(i) ^ 8'h5A, 8'hC3, 8'(d)};
            mem[d][0] = 32'hDEADBEEF;
        end
        test_reset();
        test_lat1_stores();
        test_low_addr_bits();
        test_lat3_stores();
        test_reserved();
        test_back_to_back();
        test_reset_during_read();
        test_reset_during_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
